// File: rtl/st7735_pattern_source.sv
// rtl/st7735_pattern_source.sv - Raster test-pattern RGB565 pixel stream source for the ST7735 driver
module st7735_pattern_source #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 80,
    parameter int GAP_CYCLES = 16
) (
    input  logic                    SYSTEM_CLK,
    input  logic                    SYSTEM_RST,
    input  logic                    ENABLE,
    input  logic [1:0]              PATTERN,
    input  logic [15:0]             SOLID_COLOR,
    input  logic                    PIXEL_READY,
    output logic                    PIXEL_VALID,
    output logic [15:0]             PIXEL_DATA,
    output logic [$clog2(WIDTH):0]  PIXEL_X,
    output logic [$clog2(HEIGHT):0] PIXEL_Y,
    output logic                    FRAME_START,
    output logic                    FRAME_END,
    output logic [7:0]              FRAME_COUNT
);
    localparam int XW = $clog2(WIDTH) + 1;
    localparam int YW = $clog2(HEIGHT) + 1;
    localparam int BW = $clog2(WIDTH / 8) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(WIDTH / 8 - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

    state_t        state, nxt_state;
    logic [1:0]    pat_q, nxt_pat;
    logic [15:0]   solid_q, nxt_solid;
    logic [BW-1:0] bar_cnt, nxt_bar_cnt;
    logic [2:0]    bar_idx, nxt_bar_idx;
    logic [GW-1:0] gap_cnt, nxt_gap_cnt;
    logic          nxt_valid, nxt_fs, nxt_fe;
    logic [15:0]   nxt_data;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic [7:0]    nxt_count;
    logic          load;

    // Colour of one pixel; bar index comes from the column-group counter, so no divider is needed.
    function automatic logic [15:0] pixel_of(input logic [1:0] pat, input logic [15:0] solid,
                                             input logic [XW-1:0] x, input logic [YW-1:0] y,
                                             input logic [2:0] bar);
        logic [15:0] xe, ye, px;
        xe = 16'(x);
        ye = 16'(y);
        case (pat)
            2'd0: px = solid;
            2'd1: begin
                case (bar)
                    3'd0:    px = 16'hFFFF;
                    3'd1:    px = 16'hFFE0;
                    3'd2:    px = 16'h07FF;
                    3'd3:    px = 16'h07E0;
                    3'd4:    px = 16'hF81F;
                    3'd5:    px = 16'hF800;
                    3'd6:    px = 16'h001F;
                    default: px = 16'h0000;
                endcase
            end
            2'd2:    px = {xe[7:3], ye[6:1], 5'b00000};
            default: px = (xe[3] ^ ye[3]) ? 16'h0000 : solid;
        endcase
        return px;
    endfunction

    // Next-state and next-output logic: frame load, raster advance on transfer, inter-frame gap.
    always_comb begin
        nxt_state   = state;
        nxt_pat     = pat_q;
        nxt_solid   = solid_q;
        nxt_bar_cnt = bar_cnt;
        nxt_bar_idx = bar_idx;
        nxt_gap_cnt = gap_cnt;
        nxt_valid   = PIXEL_VALID;
        nxt_data    = PIXEL_DATA;
        nxt_x       = PIXEL_X;
        nxt_y       = PIXEL_Y;
        nxt_fs      = FRAME_START;
        nxt_fe      = FRAME_END;
        nxt_count   = FRAME_COUNT;
        load        = 1'b0;
        case (state)
            S_IDLE: begin
                if (ENABLE) begin
                    load = 1'b1;
                end
            end
            S_STREAM: begin
                if (PIXEL_VALID && PIXEL_READY) begin
                    nxt_fs = 1'b0;
                    if (PIXEL_X == X_LAST && PIXEL_Y == Y_LAST) begin
                        nxt_valid   = 1'b0;
                        nxt_fe      = 1'b0;
                        nxt_count   = FRAME_COUNT + 8'd1;
                        nxt_gap_cnt = GAP_LOAD;
                        nxt_state   = S_GAP;
                    end else begin
                        if (PIXEL_X == X_LAST) begin
                            nxt_x       = '0;
                            nxt_y       = PIXEL_Y + YW'(1);
                            nxt_bar_cnt = '0;
                            nxt_bar_idx = 3'd0;
                        end else begin
                            nxt_x = PIXEL_X + XW'(1);
                            if (bar_cnt == BAR_LAST) begin
                                nxt_bar_cnt = '0;
                                nxt_bar_idx = bar_idx + 3'd1;
                            end else begin
                                nxt_bar_cnt = bar_cnt + BW'(1);
                            end
                        end
                        nxt_fe   = (nxt_x == X_LAST) && (nxt_y == Y_LAST);
                        nxt_data = pixel_of(pat_q, solid_q, nxt_x, nxt_y, nxt_bar_idx);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    if (ENABLE) begin
                        load = 1'b1;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end else begin
                    nxt_gap_cnt = gap_cnt - GW'(1);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
        if (load) begin
            nxt_state   = S_STREAM;
            nxt_pat     = PATTERN;
            nxt_solid   = SOLID_COLOR;
            nxt_bar_cnt = '0;
            nxt_bar_idx = 3'd0;
            nxt_x       = '0;
            nxt_y       = '0;
            nxt_valid   = 1'b1;
            nxt_fs      = 1'b1;
            nxt_fe      = 1'b0;
            nxt_data    = pixel_of(PATTERN, SOLID_COLOR, '0, '0, 3'd0);
        end
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            solid_q     <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            gap_cnt     <= '0;
            PIXEL_VALID <= 1'b0;
            PIXEL_DATA  <= '0;
            PIXEL_X     <= '0;
            PIXEL_Y     <= '0;
            FRAME_START <= 1'b0;
            FRAME_END   <= 1'b0;
            FRAME_COUNT <= '0;
        end else begin
            state       <= nxt_state;
            pat_q       <= nxt_pat;
            solid_q     <= nxt_solid;
            bar_cnt     <= nxt_bar_cnt;
            bar_idx     <= nxt_bar_idx;
            gap_cnt     <= nxt_gap_cnt;
            PIXEL_VALID <= nxt_valid;
            PIXEL_DATA  <= nxt_data;
            PIXEL_X     <= nxt_x;
            PIXEL_Y     <= nxt_y;
            FRAME_START <= nxt_fs;
            FRAME_END   <= nxt_fe;
            FRAME_COUNT <= nxt_count;
        end
    end
endmodule

// File: tb/tb_st7735_pattern_source.sv
// tb/tb_st7735_pattern_source.sv - Scoreboard testbench for st7735_pattern_source
module tb_st7735_pattern_source;
    localparam int W    = 160;
    localparam int H    = 80;
    localparam int GAP  = 16;
    localparam int XW   = $clog2(W) + 1;
    localparam int YW   = $clog2(H) + 1;
    localparam int W2   = 16;
    localparam int H2   = 2;
    localparam int GAP2 = 3;

    typedef struct packed {
        logic [15:0]   d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fs;
        logic          fe;
    } pix_t;

    typedef struct packed {
        logic [15:0]   d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } spot_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, ready;
    logic [1:0]    pattern;
    logic [15:0]   solid;
    logic          valid, fs, fe;
    logic [15:0]   data;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [7:0]    fc;

    logic          rst2, en2, ready2;
    logic [1:0]    pattern2;
    logic [15:0]   solid2;
    logic          valid2, fs2, fe2;
    logic [15:0]   data2;
    logic [$clog2(W2):0] px2;
    logic [$clog2(H2):0] py2;
    logic [7:0]    fc2;

    st7735_pattern_source #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP)) dut (
        .SYSTEM_CLK(clk), .SYSTEM_RST(rst), .ENABLE(enable), .PATTERN(pattern),
        .SOLID_COLOR(solid), .PIXEL_READY(ready), .PIXEL_VALID(valid), .PIXEL_DATA(data),
        .PIXEL_X(px), .PIXEL_Y(py), .FRAME_START(fs), .FRAME_END(fe), .FRAME_COUNT(fc)
    );

    st7735_pattern_source #(.WIDTH(W2), .HEIGHT(H2), .GAP_CYCLES(GAP2)) dut2 (
        .SYSTEM_CLK(clk), .SYSTEM_RST(rst2), .ENABLE(en2), .PATTERN(pattern2),
        .SOLID_COLOR(solid2), .PIXEL_READY(ready2), .PIXEL_VALID(valid2), .PIXEL_DATA(data2),
        .PIXEL_X(px2), .PIXEL_Y(py2), .FRAME_START(fs2), .FRAME_END(fe2), .FRAME_COUNT(fc2)
    );

    pix_t  sb[$];
    spot_t spots[$];
    int    n_pass = 0;
    int    n_total = 0;
    bit    rnd_ready = 1'b0;
    logic [7:0]  exp_fc = 8'd0;
    bit    prev_hold = 1'b0;
    logic [39:0] prev_vec = '0;
    bit    gap_pending = 1'b0;
    bit    fc_pending = 1'b0;
    int    gap_low = 0;
    int    in_frame = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic logic [15:0] model(input int pat, input logic [15:0] s, input int x, input int y);
        logic [15:0] xv, yv;
        xv = 16'(x);
        yv = 16'(y);
        case (pat)
            0: return s;
            1: begin
                case (x / (W / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2: return {xv[7:3], yv[6:1], 5'b00000};
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'h0000 : s;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [15:0] s);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                pix_t p;
                p.d  = model(pat, s, x, y);
                p.x  = XW'(x);
                p.y  = YW'(y);
                p.fs = (x == 0 && y == 0);
                p.fe = (x == W - 1 && y == H - 1);
                sb.push_back(p);
            end
        end
    endtask

    task automatic add_spot(input int x, input int y, input logic [15:0] d);
        spot_t s;
        s.d = d;
        s.x = XW'(x);
        s.y = YW'(y);
        spots.push_back(s);
    endtask

    task automatic wait_until(input int mode, input int limit, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            case (mode)
                0: hit = valid && px == 37 && py == 5;
                1: hit = valid && py == 40;
                2: hit = valid && fc == 8'd1 && py == 10;
                3: hit = valid && fc == 8'd2 && py == 10;
                4: hit = valid && fc == 8'd3;
                5: hit = valid && fc == 8'd3 && px == 100 && py == 0;
                default: hit = (sb.size() == 0);
            endcase
        end
        if (!hit) chk({"timeout_", name}, 40'd0, 40'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_x"}, px, 0);
        chk({tag, "_y"}, py, 0);
        chk({tag, "_fs"}, fs, 0);
        chk({tag, "_fe"}, fe, 0);
        chk({tag, "_count"}, fc, 0);
    endtask

    // Ready driver: constant high, or random 3-in-4 while rnd_ready is set.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks hold, gap and frame counting.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold   = 1'b0;
            gap_pending = 1'b0;
            fc_pending  = 1'b0;
            in_frame    = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", valid, 1);
                chk("hold_pixel", {data, px, py, fs, fe}, prev_vec);
            end
            if (fc_pending) begin
                chk("frame_count", fc, exp_fc);
                fc_pending = 1'b0;
            end
            if (gap_pending) begin
                if (!valid) gap_low++;
                else begin
                    chk("gap_len", gap_low, GAP);
                    gap_pending = 1'b0;
                end
            end
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_pixel: actual x=%0d y=%0d required none", px, py);
                end else begin
                    pix_t e;
                    e = sb.pop_front();
                    chk("pix_data", data, e.d);
                    chk("pix_xy", {px, py}, {e.x, e.y});
                    chk("pix_marks", {fs, fe}, {e.fs, e.fe});
                end
                if (spots.size() > 0 && px == spots[0].x && py == spots[0].y) begin
                    chk("spot_data", data, spots[0].d);
                    void'(spots.pop_front());
                end
                in_frame = fs ? 1 : in_frame + 1;
                if (fe) begin
                    chk("frame_len", in_frame, W * H);
                    exp_fc      = exp_fc + 8'd1;
                    fc_pending  = 1'b1;
                    gap_pending = 1'b1;
                    gap_low     = 0;
                end
            end
            prev_hold = valid && !ready;
            prev_vec  = {data, px, py, fs, fe};
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; pattern = 2'd0; solid = 16'h1234;
        rst2 = 1'b1; en2 = 1'b0; ready2 = 1'b1; pattern2 = 2'd1; solid2 = 16'h0000;
        fork
            begin : main_seq
                repeat (2) @(posedge clk);
                #1;
                check_zero("reset");
                push_frame(0, 16'h1234);
                @(negedge clk);
                rst = 1'b0;
                enable = 1'b1;
                wait_until(0, 2000, "x37_y5");
                #2 rst = 1'b1;
                #1;
                check_zero("async_reset");
                sb.delete();
                spots.delete();
                exp_fc = 8'd0;
                repeat (2) @(negedge clk);
                push_frame(0, 16'h1234);
                add_spot(0, 0, 16'h1234);
                add_spot(159, 79, 16'h1234);
                push_frame(1, 16'h0000);
                add_spot(0, 0, 16'hFFFF);
                add_spot(19, 0, 16'hFFFF);
                add_spot(20, 0, 16'hFFE0);
                add_spot(159, 0, 16'h0000);
                add_spot(159, 79, 16'h0000);
                #2 rst = 1'b0;
                wait_until(1, 20000, "solid_mid");
                pattern = 2'd1;
                solid = 16'hABCD;
                wait_until(2, 20000, "bars_mid");
                pattern = 2'd2;
                push_frame(2, 16'hABCD);
                add_spot(8, 2, 16'h0820);
                add_spot(159, 79, 16'h9CE0);
                wait_until(3, 20000, "grad_mid");
                pattern = 2'd3;
                solid = 16'hF800;
                push_frame(3, 16'hF800);
                add_spot(0, 0, 16'hF800);
                add_spot(8, 0, 16'h0000);
                add_spot(0, 8, 16'h0000);
                add_spot(8, 8, 16'hF800);
                wait_until(4, 20000, "checker_start");
                rnd_ready = 1'b1;
                wait_until(5, 2000, "pixel_100");
                enable = 1'b0;
                wait_until(6, 40000, "drain");
                repeat (GAP + 4) @(negedge clk);
                chk("idle_valid", valid, 0);
                chk("final_count", fc, 4);
                chk("spots_left", spots.size(), 0);
                rnd_ready = 1'b0;
            end
            begin : wrap_seq
                int ends;
                int n;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("lat_before", valid2, 0);
                rst2 = 1'b0;
                en2 = 1'b1;
                @(negedge clk);
                chk("lat_valid", valid2, 1);
                chk("lat_fs", fs2, 1);
                ends = 0;
                n = 0;
                while (ends < 256 && n < 256 * (W2 * H2 + GAP2) + 100) begin
                    if (valid2 && ready2 && fe2) begin
                        ends++;
                        @(negedge clk);
                        n++;
                        if (ends == 1) chk("wrap_1", fc2, 1);
                        if (ends == 255) chk("wrap_255", fc2, 255);
                        if (ends == 256) chk("wrap_0", fc2, 0);
                    end else begin
                        @(negedge clk);
                        n++;
                    end
                end
                chk("wrap_frames", ends, 256);
                en2 = 1'b0;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/st7735_pattern_source.md
# st7735_pattern_source

Upstream pixel source for the ST7735 panel driver. Generates one RGB565 frame at a time (WIDTH×HEIGHT pixels, raster order, row 0 first, x increasing) from a selectable test pattern and presents it on a valid/ready stream that the driver's pixel-write stage consumes. Includes frame start/end markers, pixel coordinates, an inter-frame gap and a frame counter, so the driver stays a pure transport.

## Interface
- WIDTH, 160, pixels per row; must be a multiple of 8.
- HEIGHT, 80, rows per frame.
- GAP_CYCLES, 16, idle cycles with VALID low after each frame; ≥1.
- SYSTEM_CLK  in  1  system clock; all logic on rising edge.
- SYSTEM_RST  in  1  reset, asynchronous and active-high.
- ENABLE  in  1  level; start and continue framing while high.
- PATTERN  in  2  0 solid, 1 colour bars, 2 gradient, 3 checkerboard; sampled at frame start.
- SOLID_COLOR  in  16  RGB565 colour for patterns 0 and 3; sampled at frame start.
- PIXEL_READY  in  1  consumer accepts the current pixel.
- PIXEL_VALID  out  1  PIXEL_DATA holds a valid pixel.
- PIXEL_DATA  out  16  RGB565 pixel.
- PIXEL_X  out  $clog2(WIDTH)+1  column of the current pixel.
- PIXEL_Y  out  $clog2(HEIGHT)+1  row of the current pixel.
- FRAME_START  out  1  high with pixel (0,0).
- FRAME_END  out  1  high with pixel (WIDTH-1,HEIGHT-1).
- FRAME_COUNT  out  8  frames completed, wraps 255→0.

## Operation
- States: IDLE, STREAM, GAP.
- Transfer occurs on a rising edge with PIXEL_VALID && PIXEL_READY.
- IDLE: VALID low. ENABLE high at an edge → latch PATTERN and SOLID_COLOR, load pixel (0,0), VALID=1, FRAME_START=1, go STREAM.
- STREAM: on transfer, advance x. At x=WIDTH-1: x←0, y+1. On transfer of the last pixel: VALID←0, FRAME_COUNT+1, gap counter←GAP_CYCLES-1, go GAP. Without a transfer, all outputs hold.
- GAP: count down each cycle. At 0: if ENABLE, latch the controls and load pixel (0,0) as in IDLE. Otherwise go IDLE.
- ENABLE falling mid-frame does not truncate the frame. The frame completes, then the block stops after GAP.
- Pixel functions (x,y current coordinates, S = latched SOLID_COLOR):
  - 0 solid: S.
  - 1 bars: index = x / (WIDTH/8). Colours 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2 gradient: {x[7:3], y[6:1], 5'b00000}. Bits beyond the counter width are 0.
  - 3 checker: (x[3]^y[3]) ? 0000 : S.
- Implement bar index with a per-row counter that resets every WIDTH/8 columns. No divider.
- Pattern and colour changes mid-frame take effect only at the next frame start.

## Timing
- Reset (async, immediate): state IDLE; PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y, FRAME_START, FRAME_END, FRAME_COUNT all 0.
- All outputs are registered. PIXEL_DATA, X, Y, FRAME_START and FRAME_END change only on a transfer or a frame load.
- VALID must not drop without a transfer. Data must be stable while VALID && !READY.
- Latency: ENABLE sampled high at edge N (IDLE) → VALID high after edge N.
- Throughput: one pixel per cycle with READY held high. A frame takes exactly WIDTH*HEIGHT transfers.
- Frame-to-frame with READY and ENABLE high: last transfer at edge M → next FRAME_START pixel valid after edge M+GAP_CYCLES.
- FRAME_COUNT increments on the edge of the last transfer.
- Reset asserted mid-frame aborts the frame. After release, the block restarts from IDLE at pixel (0,0).

## Test plan
- Reset mid-stream (x=37,y=5): all outputs 0 immediately, asynchronously. After release with ENABLE=1: first pixel (0,0) with FRAME_START=1.
- PATTERN=1, READY=1, WIDTH=160: X=0..19 gives FFFF, X=20 gives FFE0, X=159 gives 0000. FRAME_END only at (159,79). Exactly 12800 transfers. FRAME_COUNT=1.
- PATTERN=3, S=F800, READY toggling randomly: checker values are correct at every transfer, and a scoreboard shows no pixel is lost or duplicated. Data and coordinates are stable while READY is low.
- PATTERN=2: (159,79) gives {5'd19, 6'd39, 5'd0} = 9CE0. (8,2) gives 0820.
- Change PATTERN 0→1 and SOLID_COLOR mid-frame: the current frame stays solid with the old colour, and the next frame shows bars. Gap between frames is exactly GAP_CYCLES with VALID low.
- ENABLE dropped at pixel 100: the frame completes. After GAP the block is IDLE with VALID low. Running 256 frames wraps FRAME_COUNT to 0.
